arb_mux_nbit: RTL and testbench



---
 rtl/arb_pkg.sv | 28 ++
 rtl/rr_arbiter.sv | 42 ++++
 rtl/arb_mux_nbit.sv | 130 +++++++++++++
 tb/tb_arb_mux_nbit.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/arb_pkg.sv
// ---------------------------------------------------------------------------
// arb_pkg: shared definitions for the arbitrated N-bit M-to-1 multiplexer.
//   clog2      - ceiling log2, used to size the source index
//   DEF_N      - default data width per channel
//   DEF_M      - default number of input channels
//   lock_st_e  - grant-lock state encoding (used only with ARB_MUX_LOCK_EN)
// ---------------------------------------------------------------------------
package arb_pkg;

   localparam int unsigned DEF_N = 32;
   localparam int unsigned DEF_M = 4;

   typedef enum logic {
      LockOff = 1'b0,
      LockOn  = 1'b1
   } lock_st_e;

   // Bounded loop so the function stays elaboration-friendly.
   function automatic int unsigned clog2(input int unsigned v);
      int unsigned r;
      r = 0;
      for (int i = 0; i < 32; i++) begin
         if ((64'd1 << i) < 64'(v)) r = i + 1;
      end
      return r;
   endfunction

endpackage

// File: rtl/rr_arbiter.sv
// ---------------------------------------------------------------------------
// rr_arbiter: stateless round-robin grant logic.
//   req     in   M     request vector
//   ptr     in   SELW  highest-priority channel this cycle (0..M-1)
//   gnt     out  M     one-hot grant, zero when no request
//   gnt_idx out  SELW  encoded index of the granted channel (0 when none)
// The search starts at ptr and wraps upward modulo M.
// ---------------------------------------------------------------------------
module rr_arbiter #(
   parameter int unsigned M    = 4,
   parameter int unsigned SELW = 2
) (
   input  logic [M-1:0]    req,
   input  logic [SELW-1:0] ptr,
   output logic [M-1:0]    gnt,
   output logic [SELW-1:0] gnt_idx
);

   logic found;

   // Two passes: first channels at or above ptr, then the wrapped-around ones below it.
   always_comb begin
      gnt     = '0;
      gnt_idx = '0;
      found   = 1'b0;
      for (int i = 0; i < M; i++) begin
         if (!found && req[i] && (i >= int'(ptr))) begin
            gnt[i]  = 1'b1;
            gnt_idx = SELW'(i);
            found   = 1'b1;
         end
      end
      for (int i = 0; i < M; i++) begin
         if (!found && req[i] && (i < int'(ptr))) begin
            gnt[i]  = 1'b1;
            gnt_idx = SELW'(i);
            found   = 1'b1;
         end
      end
   end

endmodule

// File: rtl/arb_mux_nbit.sv
// ---------------------------------------------------------------------------
// arb_mux_nbit: registered, round-robin arbitrated N-bit M-to-1 multiplexer
// with valid/ready handshakes on every input channel and on the output.
//   clk        in   1     clock, rising edge
//   rst_n      in   1     asynchronous active-low reset
//   in_valid   in   M     per-channel request
//   in_data    in   M*N   channel i at bits [i*N +: N]
//   in_ready   out  M     per-channel accept, one-hot or zero
//   out_valid  out  1     output register holds a beat
//   out_data   out  N     data of the held beat
//   out_src    out  SELW  channel the held beat came from
//   out_ready  in   1     consumer accepts the held beat
//   in_lock    in   M     grant hold request (only with ARB_MUX_LOCK_EN)
// Optional feature macro: ARB_MUX_LOCK_EN (grant lock on in_lock).
// ---------------------------------------------------------------------------
module arb_mux_nbit
   import arb_pkg::*;
#(
   parameter int unsigned N    = DEF_N,
   parameter int unsigned M    = DEF_M,
   parameter int unsigned SELW = (M > 1) ? clog2(M) : 1
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic [M-1:0]    in_valid,
   input  logic [M*N-1:0]  in_data,
   output logic [M-1:0]    in_ready,
   output logic            out_valid,
   output logic [N-1:0]    out_data,
   output logic [SELW-1:0] out_src,
   input  logic            out_ready
`ifdef ARB_MUX_LOCK_EN
   ,
   input  logic [M-1:0]    in_lock
`endif
);

   logic [SELW-1:0] ptr_q;
   logic            out_valid_q;
   logic [N-1:0]    out_data_q;
   logic [SELW-1:0] out_src_q;

   logic [M-1:0]    req;
   logic [M-1:0]    gnt;
   logic [SELW-1:0] gnt_idx;
   logic [SELW-1:0] ptr_inc;
   logic [N-1:0]    sel_data;
   logic            can_load;
   logic            accept;

`ifdef ARB_MUX_LOCK_EN
   lock_st_e        lock_st_q;
   logic [SELW-1:0] lock_src_q;
   logic [M-1:0]    lock_mask;
   logic            lock_hit;

   // While locked only the owning channel may compete.
   always_comb begin
      lock_mask = '1;
      if (lock_st_q == LockOn) lock_mask = M'(1) << lock_src_q;
   end

   assign req      = in_valid & lock_mask;
   assign lock_hit = |(in_lock & gnt);
`else
   assign req = in_valid;
`endif

   rr_arbiter #(
      .M    (M),
      .SELW (SELW)
   ) u_arb (
      .req     (req),
      .ptr     (ptr_q),
      .gnt     (gnt),
      .gnt_idx (gnt_idx)
   );

   assign can_load = ~out_valid_q | out_ready;
   assign in_ready = gnt & {M{can_load}};
   // Grants only go to valid channels, so any ready is a handshake.
   assign accept   = |in_ready;

   assign ptr_inc = (gnt_idx == SELW'(M - 1)) ? '0 : gnt_idx + 1'b1;

   always_comb begin
      sel_data = '0;
      for (int i = 0; i < M; i++) begin
         sel_data = sel_data | (in_data[i*N +: N] & {N{gnt_idx == SELW'(i)}});
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ptr_q       <= '0;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_src_q   <= '0;
`ifdef ARB_MUX_LOCK_EN
         lock_st_q   <= LockOff;
         lock_src_q  <= '0;
`endif
      end else begin
         if (accept) begin
            out_valid_q <= 1'b1;
            out_data_q  <= sel_data;
            out_src_q   <= gnt_idx;
`ifdef ARB_MUX_LOCK_EN
            // Locked beats leave ptr alone; the releasing beat advances it.
            if (lock_hit) begin
               lock_st_q  <= LockOn;
               lock_src_q <= gnt_idx;
            end else begin
               lock_st_q  <= LockOff;
               ptr_q      <= ptr_inc;
            end
`else
            ptr_q       <= ptr_inc;
`endif
         end else if (out_ready) begin
            out_valid_q <= 1'b0;
         end
      end
   end

   assign out_valid = out_valid_q;
   assign out_data  = out_data_q;
   assign out_src   = out_src_q;

endmodule

// File: tb/tb_arb_mux_nbit.sv
// ---------------------------------------------------------------------------
// tb_arb_mux_nbit: self-checking bench for arb_mux_nbit (M=4 main instance,
// M=3 instance for non-power-of-two wrap).
// ---------------------------------------------------------------------------
module tb_arb_mux_nbit;

   typedef struct {
      logic [3:0] v;
      logic       r;
      logic [3:0] rdy;
      logic       ov;
      logic [1:0] src;
   } vec_t;

   logic        clk;
   logic        rst_n;
   logic [3:0]  in_valid;
   logic [127:0] in_data;
   logic [3:0]  in_ready;
   logic        out_valid;
   logic [31:0] out_data;
   logic [1:0]  out_src;
   logic        out_ready;

   logic [2:0]  v3;
   logic [95:0] d3;
   logic [2:0]  rdy3;
   logic        ov3;
   logic [31:0] od3;
   logic [1:0]  os3;
   logic        r3;

`ifdef ARB_MUX_LOCK_EN
   logic [3:0]  lock;
   logic [2:0]  lock3;
`endif

   logic [31:0] dat [4];
   int          n_vec;
   int          n_err;
   vec_t        tbl [24];
   vec_t        tb3 [4];

   arb_mux_nbit #(
      .N (32),
      .M (4)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_data   (in_data),
      .in_ready  (in_ready),
      .out_valid (out_valid),
      .out_data  (out_data),
      .out_src   (out_src),
      .out_ready (out_ready)
`ifdef ARB_MUX_LOCK_EN
      ,
      .in_lock   (lock)
`endif
   );

   arb_mux_nbit #(
      .N (32),
      .M (3)
   ) dut3 (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (v3),
      .in_data   (d3),
      .in_ready  (rdy3),
      .out_valid (ov3),
      .out_data  (od3),
      .out_src   (os3),
      .out_ready (r3)
`ifdef ARB_MUX_LOCK_EN
      ,
      .in_lock   (lock3)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   // Drive one cycle of the M=4 instance and check ready, then the registered result.
   task automatic apply(input vec_t t, input string tag);
      in_valid  = t.v;
      out_ready = t.r;
      #1;
      chk({tag, " in_ready"}, 32'(in_ready), 32'(t.rdy));
      @(posedge clk);
      #1;
      chk({tag, " out_valid"}, 32'(out_valid), 32'(t.ov));
      chk({tag, " out_src"}, 32'(out_src), 32'(t.src));
      chk({tag, " out_data"}, out_data, dat[t.src]);
   endtask

   task automatic apply3(input vec_t t, input string tag);
      v3 = t.v[2:0];
      r3 = t.r;
      #1;
      chk({tag, " in_ready"}, 32'(rdy3), 32'(t.rdy));
      @(posedge clk);
      #1;
      chk({tag, " out_valid"}, 32'(ov3), 32'(t.ov));
      chk({tag, " out_src"}, 32'(os3), 32'(t.src));
      chk({tag, " out_data"}, od3, dat[t.src]);
   endtask

   initial begin
      n_vec = 0;
      n_err = 0;
      dat[0] = 32'h1111_0000;
      dat[1] = 32'hDEAD_BEEF;
      dat[2] = 32'h2222_0002;
      dat[3] = 32'h3333_0003;
      in_data = {dat[3], dat[2], dat[1], dat[0]};
      d3      = {dat[2], dat[1], dat[0]};

      //         valid    rdy  ready    ov    src
      tbl[0]  = '{4'b1111, 1'b1, 4'b0001, 1'b1, 2'd0};  // round robin 0..3 twice
      tbl[1]  = '{4'b1111, 1'b1, 4'b0010, 1'b1, 2'd1};
      tbl[2]  = '{4'b1111, 1'b1, 4'b0100, 1'b1, 2'd2};
      tbl[3]  = '{4'b1111, 1'b1, 4'b1000, 1'b1, 2'd3};
      tbl[4]  = '{4'b1111, 1'b1, 4'b0001, 1'b1, 2'd0};
      tbl[5]  = '{4'b1111, 1'b1, 4'b0010, 1'b1, 2'd1};
      tbl[6]  = '{4'b1111, 1'b1, 4'b0100, 1'b1, 2'd2};
      tbl[7]  = '{4'b1111, 1'b1, 4'b1000, 1'b1, 2'd3};
      tbl[8]  = '{4'b0000, 1'b1, 4'b0000, 1'b0, 2'd3};  // drain keeps data/src
      tbl[9]  = '{4'b0101, 1'b1, 4'b0001, 1'b1, 2'd0};  // sparse 0,2 with wrap
      tbl[10] = '{4'b0101, 1'b1, 4'b0100, 1'b1, 2'd2};
      tbl[11] = '{4'b0101, 1'b1, 4'b0001, 1'b1, 2'd0};
      tbl[12] = '{4'b0000, 1'b1, 4'b0000, 1'b0, 2'd0};
      tbl[13] = '{4'b0010, 1'b1, 4'b0010, 1'b1, 2'd1};  // load DEADBEEF from 1
      tbl[14] = '{4'b1111, 1'b0, 4'b0000, 1'b1, 2'd1};  // stall x3
      tbl[15] = '{4'b1111, 1'b0, 4'b0000, 1'b1, 2'd1};
      tbl[16] = '{4'b1111, 1'b0, 4'b0000, 1'b1, 2'd1};
      tbl[17] = '{4'b1111, 1'b1, 4'b0100, 1'b1, 2'd2};  // release: next is 2
      tbl[18] = '{4'b1000, 1'b1, 4'b1000, 1'b1, 2'd3};  // drain + load ch3
      tbl[19] = '{4'b0000, 1'b0, 4'b0000, 1'b1, 2'd3};
      tbl[20] = '{4'b0000, 1'b1, 4'b0000, 1'b0, 2'd3};
      tbl[21] = '{4'b0010, 1'b0, 4'b0010, 1'b1, 2'd1};  // empty reg loads without out_ready
      tbl[22] = '{4'b0001, 1'b0, 4'b0000, 1'b1, 2'd1};
      tbl[23] = '{4'b0001, 1'b1, 4'b0001, 1'b1, 2'd0};  // ptr=2 scans 2,3,0

      tb3[0]  = '{4'b0010, 1'b1, 4'b0010, 1'b1, 2'd1};  // ptr -> 2
      tb3[1]  = '{4'b0101, 1'b1, 4'b0100, 1'b1, 2'd2};  // ptr wraps to 0
      tb3[2]  = '{4'b0101, 1'b1, 4'b0001, 1'b1, 2'd0};
      tb3[3]  = '{4'b0101, 1'b1, 4'b0100, 1'b1, 2'd2};

      rst_n     = 1'b0;
      in_valid  = '0;
      out_ready = 1'b0;
      v3        = '0;
      r3        = 1'b0;
`ifdef ARB_MUX_LOCK_EN
      lock      = '0;
      lock3     = '0;
`endif
      repeat (2) @(posedge clk);
      #1;
      chk("reset out_valid", 32'(out_valid), 32'd0);
      chk("reset out_data", out_data, 32'd0);
      chk("reset out_src", 32'(out_src), 32'd0);
      rst_n = 1'b1;

      for (int i = 0; i < 24; i++) apply(tbl[i], $sformatf("vec%0d", i));

      // Asynchronous reset while a beat is held.
      #2;
      rst_n = 1'b0;
      #1;
      chk("midreset out_valid", 32'(out_valid), 32'd0);
      chk("midreset out_data", out_data, 32'd0);
      chk("midreset out_src", 32'(out_src), 32'd0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      apply('{4'b1111, 1'b1, 4'b0001, 1'b1, 2'd0}, "post_reset");
      apply('{4'b0000, 1'b1, 4'b0000, 1'b0, 2'd0}, "post_reset_drain");

      for (int i = 0; i < 4; i++) apply3(tb3[i], $sformatf("m3_%0d", i));
      v3 = '0;

`ifdef ARB_MUX_LOCK_EN
      // ptr is 1 here: ch1 locks for two beats, releases on the third.
      lock = 4'b0010;
      apply('{4'b0111, 1'b1, 4'b0010, 1'b1, 2'd1}, "lock0");
      apply('{4'b0111, 1'b1, 4'b0010, 1'b1, 2'd1}, "lock1");
      lock = 4'b0000;
      apply('{4'b0111, 1'b1, 4'b0010, 1'b1, 2'd1}, "lock2");
      apply('{4'b0111, 1'b1, 4'b0100, 1'b1, 2'd2}, "lock3");
      apply('{4'b0111, 1'b1, 4'b0001, 1'b1, 2'd0}, "lock4");
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
